imm_ext_arbiter: RTL
====================

// Module: imm_ext_arbiter
// PURPOSE
//  Shares the single immediate extender between two requesters: port A (decode) and port B (branch-target precompute).
//  Arbitrates round-robin, decodes the opcode to an immediate type, drives the extender, and registers its result.
//  Returns the result over a valid/ready response channel, tagged with the source port.
// PARAMETERS
//  XLEN        32  datapath width (from Parameters.vh)
//  TAG_W       4   requester tag width, returned unchanged with the response
//  IMM_TYPE_W  3   width of the imm-type code sent to the extender (from Parameters.vh)
// PORTS
//  clk           in   1           single clock, rising edge
//  rst           in   1           reset, asynchronous, active-high
//  a_valid       in   1           port A request
//  a_ready       out  1           port A accept (combinational)
//  a_instr       in   32          port A instruction word
//  a_tag         in   TAG_W       port A tag
//  b_valid/b_ready/b_instr/b_tag  as port A, for port B
//  ext_instr     out  25          instr[31:7] of the granted request, to extender
//  ext_imm_type  out  IMM_TYPE_W  decoded imm type, to extender
//  ext_imm       in   XLEN        extender result (combinational path)
//  rsp_valid     out  1           response valid
//  rsp_ready     in   1           response consumer ready
//  rsp_imm       out  XLEN        extended immediate
//  rsp_src       out  1           0 = port A, 1 = port B
//  rsp_tag       out  TAG_W       tag of the served request
//  rsp_illegal   out  1           opcode carries no immediate
// BEHAVIOUR
//  Reset (async, rst=1): state=IDLE, rr_ptr=A.
//   All registered outputs = 0, including rsp_valid, rsp_imm, rsp_tag and rsp_illegal. A request in flight is dropped.
//  FSM states and transitions:
//   IDLE: if any valid, grant one requester, raise its ready, latch instr/tag/src. Go to EXT.
//   EXT: ext_* driven from the latch. Capture ext_imm into rsp_imm, set rsp_valid=1. Go to HOLD.
//   HOLD: rsp_* held stable while rsp_ready=0.
//    On rsp_valid & rsp_ready: if any valid, accept in the same cycle and go to EXT. Otherwise go to IDLE.
//  Accept rule: x_ready = (IDLE | (HOLD & rsp_ready)) & grant_x. At most one ready high per cycle.
//   A transfer occurs on x_valid & x_ready.
//  Arbitration: only one valid -> grant it. Both valid -> grant the port opposite rr_ptr's last grant.
//   rr_ptr updates on each accept. First grant after reset = A.
//  Latency: accept at cycle N -> rsp_valid at N+2 (registered). Peak throughput: 1 response per 2 cycles.
//  Opcode decode (instr[6:0]):
//   0000011, 0010011, 1100111 -> I
//   0100011 -> S;  1100011 -> B;  0110111, 0010111 -> U;  1101111 -> J
//   Anything else -> rsp_illegal=1, rsp_imm=0, with the same latency and handshake.
//  Extender contract: ext_imm is valid in the same cycle as ext_instr/ext_imm_type; no internal extender register.
//  Outside EXT, ext_instr and ext_imm_type hold their last value (no X on outputs).
//  Requester rule: a requester must hold valid, instr and tag stable until ready. A dropped valid before ready is legal.
//  The block never raises ready while rsp_valid is held unconsumed.
// STRUCTURE
//  Parameters.vh: XLEN, IMM_TYPE_W, the imm-type codes I/S/B/U/J, opcode constants, and FSM state encodings.
//  One sub-module: imm_type_decode (combinational, instr[6:0] -> {imm_type, illegal}).
//  FSM, round-robin pointer, request latch and response register live in the top module.
// TESTING
//  1 A only, a_instr=32'hFFF00093, tag=3, rsp_ready=1 -> rsp_imm=32'hFFFFFFFF, src=0, tag=3, illegal=0, 2 cycles after accept.
//  2 B only, b_instr=32'h0020A423 (sw) -> imm=32'h00000008, src=1.
//    b_instr=32'hFFDFF06F (jal -4) -> imm=32'hFFFFFFFC.
//  3 A and B valid in the first cycle after reset, held -> A served first, then B.
//    Alternation continues A,B,A,B while both stay valid; responses are back-to-back every 2 cycles.
//  4 a_instr=32'h123452B7 (lui), rsp_ready=0 for 5 cycles -> rsp_valid, rsp_imm=32'h12345000 and tag stay stable.
//    a_ready and b_ready stay 0 until the handshake completes.
//  5 a_instr=32'h0000007F -> rsp_illegal=1, rsp_imm=0, normal latency.
//  6 Assert rst in EXT and again in HOLD -> rsp_valid=0 and readies=0 immediately (async).
//    After release, the next request is granted to A with correct output.

Source files
------------

// File: rtl/imm_ext_arbiter_pkg.sv
// Shared types and constants for the immediate-extender arbiter.
//   XLEN / TAG_W / IMM_TYPE_W : default datapath, tag and imm-type widths
//   imm_type_e                : imm-type codes understood by the extender
//   OPC_*                     : opcode constants (instr[6:0])
//   state_e                   : arbiter FSM state encoding
//   src_e                     : requester identity (port A / port B)
package imm_ext_arbiter_pkg;

  localparam int XLEN       = 32;
  localparam int TAG_W      = 4;
  localparam int IMM_TYPE_W = 3;

  typedef enum logic [IMM_TYPE_W-1:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4
  } imm_type_e;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXT  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  typedef enum logic {
    SRC_A = 1'b0,
    SRC_B = 1'b1
  } src_e;

endpackage

// File: rtl/imm_ext_arbiter_decode.sv
// Combinational opcode decoder: instr[6:0] -> {imm type, illegal}.
//   i_opcode   : instr[6:0]
//   o_imm_type : imm-type code for the extender (IMM_I when illegal)
//   o_illegal  : opcode carries no immediate
module imm_type_decode
  import imm_ext_arbiter_pkg::*;
(
  input  logic [6:0] i_opcode,
  output imm_type_e  o_imm_type,
  output logic       o_illegal
);

  always_comb begin
    o_imm_type = IMM_I;
    o_illegal  = 1'b0;
    case (i_opcode)
      OPC_LOAD, OPC_OP_IMM, OPC_JALR: o_imm_type = IMM_I;
      OPC_STORE:                      o_imm_type = IMM_S;
      OPC_BRANCH:                     o_imm_type = IMM_B;
      OPC_LUI, OPC_AUIPC:             o_imm_type = IMM_U;
      OPC_JAL:                        o_imm_type = IMM_J;
      default:                        o_illegal  = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_ext_arbiter.sv
// Round-robin arbiter sharing one immediate extender between two requesters.
//   i_clk, i_rst                          : clock, async active-high reset
//   i_a_* / o_a_ready, i_b_* / o_b_ready  : requester ports (valid/ready)
//   o_ext_instr, o_ext_imm_type, i_ext_imm: combinational extender interface
//   o_rsp_*, i_rsp_ready                  : tagged response channel
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_IDLE | no request in flight, accepts the granted requester
// ST_EXT  | extender driven from the latch, result captured this cycle
// ST_HOLD | response presented; accepts next request on rsp handshake
module imm_ext_arbiter
  import imm_ext_arbiter_pkg::*;
#(
  parameter int P_XLEN  = XLEN,
  parameter int P_TAG_W = TAG_W
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_a_valid,
  output logic               o_a_ready,
  input  logic [31:0]        i_a_instr,
  input  logic [P_TAG_W-1:0] i_a_tag,
  input  logic               i_b_valid,
  output logic               o_b_ready,
  input  logic [31:0]        i_b_instr,
  input  logic [P_TAG_W-1:0] i_b_tag,
  output logic [24:0]        o_ext_instr,
  output imm_type_e          o_ext_imm_type,
  input  logic [P_XLEN-1:0]  i_ext_imm,
  output logic               o_rsp_valid,
  input  logic               i_rsp_ready,
  output logic [P_XLEN-1:0]  o_rsp_imm,
  output logic               o_rsp_src,
  output logic [P_TAG_W-1:0] o_rsp_tag,
  output logic               o_rsp_illegal
);

  state_e             r_state;
  src_e               r_rr_prio;
  logic [24:0]        r_ext_instr;
  imm_type_e          r_ext_imm_type;
  logic               r_lat_illegal;
  logic [P_TAG_W-1:0] r_lat_tag;
  src_e               r_lat_src;
  logic               r_rsp_valid;
  logic [P_XLEN-1:0]  r_rsp_imm;
  src_e               r_rsp_src;
  logic [P_TAG_W-1:0] r_rsp_tag;
  logic               r_rsp_illegal;

  logic        w_grant_a;
  logic        w_grant_b;
  logic        w_accept_en;
  logic        w_accept;
  logic [31:0] w_sel_instr;
  imm_type_e   w_dec_type;
  logic        w_dec_illegal;

  // r_rr_prio names the port that wins a tie; a lone requester always wins.
  assign w_grant_b = i_b_valid & (~i_a_valid | (r_rr_prio == SRC_B));
  assign w_grant_a = i_a_valid & ~w_grant_b;

  // Ready is gated by reset so it drops the instant reset is asserted.
  assign w_accept_en = ~i_rst & ((r_state == ST_IDLE) |
                                 ((r_state == ST_HOLD) & i_rsp_ready));
  assign o_a_ready   = w_accept_en & w_grant_a;
  assign o_b_ready   = w_accept_en & w_grant_b;
  assign w_accept    = o_a_ready | o_b_ready;
  assign w_sel_instr = w_grant_b ? i_b_instr : i_a_instr;

  imm_type_decode u_decode (
    .i_opcode   (w_sel_instr[6:0]),
    .o_imm_type (w_dec_type),
    .o_illegal  (w_dec_illegal)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state        <= ST_IDLE;
      r_rr_prio      <= SRC_A;
      r_ext_instr    <= '0;
      r_ext_imm_type <= IMM_I;
      r_lat_illegal  <= 1'b0;
      r_lat_tag      <= '0;
      r_lat_src      <= SRC_A;
      r_rsp_valid    <= 1'b0;
      r_rsp_imm      <= '0;
      r_rsp_src      <= SRC_A;
      r_rsp_tag      <= '0;
      r_rsp_illegal  <= 1'b0;
    end else begin
      // The request latch doubles as the extender drive registers, so the
      // extender inputs hold their last value outside ST_EXT.
      if (w_accept) begin
        r_ext_instr    <= w_sel_instr[31:7];
        r_ext_imm_type <= w_dec_type;
        r_lat_illegal  <= w_dec_illegal;
        r_lat_tag      <= w_grant_b ? i_b_tag : i_a_tag;
        r_lat_src      <= w_grant_b ? SRC_B : SRC_A;
        r_rr_prio      <= w_grant_b ? SRC_A : SRC_B;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_accept) r_state <= ST_EXT;
        end
        ST_EXT: begin
          r_rsp_imm     <= r_lat_illegal ? '0 : i_ext_imm;
          r_rsp_valid   <= 1'b1;
          r_rsp_src     <= r_lat_src;
          r_rsp_tag     <= r_lat_tag;
          r_rsp_illegal <= r_lat_illegal;
          r_state       <= ST_HOLD;
        end
        ST_HOLD: begin
          if (i_rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= w_accept ? ST_EXT : ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_ext_instr    = r_ext_instr;
  assign o_ext_imm_type = r_ext_imm_type;
  assign o_rsp_valid    = r_rsp_valid;
  assign o_rsp_imm      = r_rsp_imm;
  assign o_rsp_src      = r_rsp_src;
  assign o_rsp_tag      = r_rsp_tag;
  assign o_rsp_illegal  = r_rsp_illegal;

endmodule
